reg_file_4x: RTL and testbench

//   Four-entry register bank with one write port and two synchronous read ports.

---
 rtl/reg_file_4x.sv | 77 +++++++
 tb/tb_reg_file_4x.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_4x.sv
// rtl/reg_file_4x.sv - four-entry register bank, one write port, two registered read ports
module reg_file_4x #(
  parameter int WIDTH    = 8,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       raddr_a,
  input  logic [1:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_written,
  output logic [3:0]       written
);

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic [3:0]       written_q, written_d;
  logic             wr_accept;

  // Writes to the hard-wired zero entry are dropped entirely.
  assign wr_accept = we && !(ZERO_REG && (waddr == 2'd0));

  // Read value for one port: zero entry first, then same-edge forwarding, then storage.
  function automatic logic [WIDTH-1:0] read_value(input logic [1:0] addr);
    if (ZERO_REG && (addr == 2'd0)) begin
      return '0;
    end else if (wr_accept && (waddr == addr)) begin
      return wdata;
    end else begin
      return regs_q[addr];
    end
  endfunction

  // Next-state for storage, read registers and the sticky written bitmap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    rdata_a_d = read_value(raddr_a);
    rdata_b_d = read_value(raddr_b);
    written_d = clr_written ? 4'b0000 : written_q;
    if (wr_accept) begin
      regs_d[waddr]    = wdata;
      written_d[waddr] = 1'b1;
    end
  end

  // State register; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      written_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      written_q <= written_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign written = written_q;

endmodule

// File: tb/tb_reg_file_4x.sv
// tb/tb_reg_file_4x.sv - randomized and directed checks of reg_file_4x against a reference model
module tb_reg_file_4x;

  logic       clk;
  logic       rst;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic       clr_written;

  // Index 0: zero register enabled; index 1: entry 0 is a normal register.
  logic [7:0] rdata_a [2];
  logic [7:0] rdata_b [2];
  logic [3:0] written [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state, one set per instance.
  logic [7:0] m_regs [2][4];
  logic [7:0] m_ra   [2];
  logic [7:0] m_rb   [2];
  logic [3:0] m_wr   [2];

  reg_file_4x #(.WIDTH(8), .ZERO_REG(1'b1)) u_z1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a[0]), .rdata_b(rdata_b[0]),
    .clr_written(clr_written), .written(written[0])
  );

  reg_file_4x #(.WIDTH(8), .ZERO_REG(1'b0)) u_z0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a[1]), .rdata_b(rdata_b[1]),
    .clr_written(clr_written), .written(written[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m_regs[k][i] = 8'h00;
      m_ra[k] = 8'h00;
      m_rb[k] = 8'h00;
      m_wr[k] = 4'b0000;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val({tag, (k == 0) ? "_z1_a" : "_z0_a"}, {24'h0, rdata_a[k]}, {24'h0, m_ra[k]});
      check_val({tag, (k == 0) ? "_z1_b" : "_z0_b"}, {24'h0, rdata_b[k]}, {24'h0, m_rb[k]});
      check_val({tag, (k == 0) ? "_z1_w" : "_z0_w"}, {28'h0, written[k]}, {28'h0, m_wr[k]});
    end
  endtask

  // One clock: model what the edge should do with the current inputs, then compare.
  task automatic cycle(input string tag);
    logic [7:0] nxt_regs [4];
    logic [7:0] nxt_a;
    logic [7:0] nxt_b;
    logic [3:0] nxt_w;
    bit         zero_on;
    bit         taken;
    for (int k = 0; k < 2; k++) begin
      zero_on = (k == 0);
      taken   = we && !(zero_on && waddr == 2'd0);
      for (int i = 0; i < 4; i++) nxt_regs[i] = m_regs[k][i];
      if (taken) nxt_regs[waddr] = wdata;
      nxt_a = (zero_on && raddr_a == 2'd0) ? 8'h00 : nxt_regs[raddr_a];
      nxt_b = (zero_on && raddr_b == 2'd0) ? 8'h00 : nxt_regs[raddr_b];
      nxt_w = clr_written ? 4'b0000 : m_wr[k];
      if (taken) nxt_w = nxt_w | (4'b0001 << waddr);
      for (int i = 0; i < 4; i++) m_regs[k][i] = nxt_regs[i];
      m_ra[k] = nxt_a;
      m_rb[k] = nxt_b;
      m_wr[k] = nxt_w;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic clr);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; clr_written = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 2'd3, 8'h77, 2'd3, 2'd3, 1'b0);
    model_clear();
    #2;
    check_all("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write then read.
    drive(1'b1, 2'd2, 8'hA5, 2'd0, 2'd0, 1'b0);
    cycle("wr_a5");
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0);
    cycle("rd_a5");
    check_val("rd_a5_const", {24'h0, rdata_a[0]}, 32'hA5);

    // Forwarding over an old value on both ports.
    drive(1'b1, 2'd1, 8'h11, 2'd2, 2'd2, 1'b0);
    cycle("wr_11");
    drive(1'b1, 2'd1, 8'h3C, 2'd1, 2'd1, 1'b0);
    cycle("fwd");
    check_val("fwd_a_const", {24'h0, rdata_a[0]}, 32'h3C);
    check_val("fwd_b_const", {24'h0, rdata_b[1]}, 32'h3C);

    // Zero register versus normal entry 0.
    drive(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 1'b0);
    cycle("zero");
    check_val("zero_z1_rb", {24'h0, rdata_b[0]}, 32'h00);
    check_val("zero_z1_w0", {31'h0, written[0][0]}, 32'h0);
    check_val("zero_z0_rb", {24'h0, rdata_b[1]}, 32'hFF);
    check_val("zero_z0_w0", {31'h0, written[1][0]}, 32'h1);
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
    cycle("zero_hold");
    check_val("zero_hold_z0", {24'h0, rdata_a[1]}, 32'hFF);

    // Bitmap: clear, set 1 and 3, then clear together with a write to 2.
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b1);
    cycle("bm_clr");
    drive(1'b1, 2'd1, 8'h21, 2'd1, 2'd3, 1'b0);
    cycle("bm_w1");
    drive(1'b1, 2'd3, 8'h43, 2'd1, 2'd3, 1'b0);
    cycle("bm_w3");
    check_val("bm_1010", {28'h0, written[0]}, 32'hA);
    drive(1'b1, 2'd2, 8'h62, 2'd2, 2'd3, 1'b1);
    cycle("bm_clrw2");
    check_val("bm_0100", {28'h0, written[0]}, 32'h4);
    check_val("bm_0100_z0", {28'h0, written[1]}, 32'h4);

    // Reset mid-run with a write pending; outputs must clear before the next edge.
    drive(1'b1, 2'd3, 8'hEE, 2'd3, 2'd1, 1'b0);
    #3;
    rst = 1'b1;
    model_clear();
    #1;
    check_all("reset_mid");
    @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 1'b0);
    cycle("post_reset");
    check_val("post_reset_e3", {24'h0, rdata_a[1]}, 32'h00);

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0);
      cycle("sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, reached %0t expected under 200000", $time);
    $fatal(1);
  end

endmodule
